// File: rtl/risc_v_decode_queue_if.sv
// Handshake bundle between an instruction producer and the decode queue.
// The master drives instructions in and takes decoded entries out.
interface risc_v_decode_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            flush;
  logic            in_valid;
  logic [31:0]     instr;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            illegal;
  logic [CW-1:0]   count;

  modport master (
    output flush, in_valid, instr, out_ready,
    input  in_ready, out_valid, opcode, rd, rs1, rs2,
    input  func3, func7, imm, fmt, illegal, count
  );

  modport slave (
    input  flush, in_valid, instr, out_ready,
    output in_ready, out_valid, opcode, rd, rs1, rs2,
    output func3, func7, imm, fmt, illegal, count
  );
endinterface

// File: rtl/risc_v_decode_queue.sv
// RV instruction decode queue: decodes at push and stores decoded
// entries in a DEPTH-deep FIFO so the output path is register-only.
module risc_v_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  risc_v_decode_queue_if.slave q
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic          w_ready;
  logic [31:0]   w_i;
  logic [31:0]   w_imm32;
  entry_t        w_dec;
  entry_t        w_head;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_i     = q.instr;
  assign w_valid = (r_count != '0);
  assign w_ready = (r_count < CW'(DEPTH));
  assign w_push  = q.in_valid && w_ready;
  assign w_pop   = w_valid && q.out_ready;

  always_comb begin
    w_dec        = '0;
    w_imm32      = '0;
    w_dec.opcode = w_i[6:0];
    w_dec.rd     = w_i[11:7];
    w_dec.func3  = w_i[14:12];
    w_dec.rs1    = w_i[19:15];
    w_dec.rs2    = w_i[24:20];
    w_dec.func7  = w_i[31:25];
    unique case (w_i[6:0])
      7'b0110011: w_dec.fmt = 3'd0;
      7'b0010011, 7'b0000011,
      7'b1100111, 7'b1110011: begin
        w_dec.fmt = 3'd1;
        w_imm32   = {{20{w_i[31]}}, w_i[31:20]};
      end
      7'b0100011: begin
        w_dec.fmt = 3'd2;
        w_imm32   = {{20{w_i[31]}}, w_i[31:25],
                     w_i[11:7]};
      end
      7'b1100011: begin
        w_dec.fmt = 3'd3;
        w_imm32   = {{19{w_i[31]}}, w_i[31], w_i[7],
                     w_i[30:25], w_i[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_dec.fmt = 3'd4;
        w_imm32   = {w_i[31:12], 12'b0};
      end
      7'b1101111: begin
        w_dec.fmt = 3'd5;
        w_imm32   = {{11{w_i[31]}}, w_i[31],
                     w_i[19:12], w_i[20],
                     w_i[30:21], 1'b0};
      end
      default: begin
        w_dec.fmt     = 3'd7;
        w_dec.illegal = 1'b1;
      end
    endcase
    w_dec.imm = XLEN'($signed(w_imm32));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (q.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= nxt(r_wptr);
      if (w_pop)  r_rptr <= nxt(r_rptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (w_push && !q.flush) r_mem[r_wptr] <= w_dec;
  end

  assign w_head      = w_valid ? r_mem[r_rptr] : '0;
  assign q.in_ready  = w_ready;
  assign q.out_valid = w_valid;
  assign q.count     = r_count;
  assign q.opcode    = w_head.opcode;
  assign q.rd        = w_head.rd;
  assign q.rs1       = w_head.rs1;
  assign q.rs2       = w_head.rs2;
  assign q.func3     = w_head.func3;
  assign q.func7     = w_head.func7;
  assign q.imm       = w_head.imm;
  assign q.fmt       = w_head.fmt;
  assign q.illegal   = w_head.illegal;
endmodule

// File: tb/tb_risc_v_decode_queue.sv
// Bench for risc_v_decode_queue: table vectors, corner sequences and
// random traffic against a queue-of-words reference model.
module tb_risc_v_decode_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  risc_v_decode_queue_if #(.XLEN(32), .DEPTH(2)) q32 ();
  risc_v_decode_queue_if #(.XLEN(64), .DEPTH(3)) q64 ();

  risc_v_decode_queue #(.XLEN(32), .DEPTH(2)) u32 (
    .clk(clk), .rst(rst), .q(q32.slave)
  );
  risc_v_decode_queue #(.XLEN(64), .DEPTH(3)) u64 (
    .clk(clk), .rst(rst), .q(q64.slave)
  );

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic        illegal;
    logic [63:0] imm;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [31:0] mq0 [$];
  logic [31:0] mq1 [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v,
                                     input int n);
    logic [63:0] z;
    z = {32'b0, v};
    return v[n-1] ? (z - (64'd1 << n)) : z;
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t e;
    e = '0;
    e.opcode = w[6:0];
    e.rd = w[11:7];
    e.func3 = w[14:12];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.func7 = w[31:25];
    case (w[6:0])
      7'h33: e.fmt = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73: begin
        e.fmt = 3'd1;
        e.imm = sx({20'b0, w[31:20]}, 12);
      end
      7'h23: begin
        e.fmt = 3'd2;
        e.imm = sx({20'b0, w[31:25], w[11:7]}, 12);
      end
      7'h63: begin
        e.fmt = 3'd3;
        e.imm = sx({19'b0, w[31], w[7], w[30:25],
                    w[11:8], 1'b0}, 13);
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4;
        e.imm = sx({w[31:12], 12'b0}, 32);
      end
      7'h6F: begin
        e.fmt = 3'd5;
        e.imm = sx({11'b0, w[31], w[19:12], w[20],
                    w[30:21], 1'b0}, 21);
      end
      default: begin
        e.fmt = 3'd7;
        e.illegal = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic chk_state(input int w);
    int sz;
    int dp;
    exp_t e;
    exp_t a;
    logic av, ar;
    logic [63:0] ac;
    sz = (w != 0) ? mq1.size() : mq0.size();
    dp = (w != 0) ? 3 : 2;
    e = '0;
    if (sz > 0) e = ref_dec((w != 0) ? mq1[0] : mq0[0]);
    if (w == 0) e.imm = {32'b0, e.imm[31:0]};
    if (w == 0) begin
      av = q32.out_valid; ar = q32.in_ready;
      ac = 64'(q32.count);
      a = '{q32.opcode, q32.rd, q32.rs1, q32.rs2, q32.func3,
            q32.func7, 64'(q32.imm), q32.fmt, q32.illegal};
    end else begin
      av = q64.out_valid; ar = q64.in_ready;
      ac = 64'(q64.count);
      a = '{q64.opcode, q64.rd, q64.rs1, q64.rs2, q64.func3,
            q64.func7, q64.imm, q64.fmt, q64.illegal};
    end
    chk($sformatf("out_valid%0d", w), 64'(av), 64'(sz != 0));
    chk($sformatf("in_ready%0d", w), 64'(ar), 64'(sz < dp));
    chk($sformatf("count%0d", w), ac, 64'(sz));
    chk($sformatf("opcode%0d", w), 64'(a.opcode), 64'(e.opcode));
    chk($sformatf("rd%0d", w), 64'(a.rd), 64'(e.rd));
    chk($sformatf("rs1_%0d", w), 64'(a.rs1), 64'(e.rs1));
    chk($sformatf("rs2_%0d", w), 64'(a.rs2), 64'(e.rs2));
    chk($sformatf("func3_%0d", w), 64'(a.func3), 64'(e.func3));
    chk($sformatf("func7_%0d", w), 64'(a.func7), 64'(e.func7));
    chk($sformatf("imm%0d", w), a.imm, e.imm);
    chk($sformatf("fmt%0d", w), 64'(a.fmt), 64'(e.fmt));
    chk($sformatf("illegal%0d", w), 64'(a.illegal),
        64'(e.illegal));
  endtask

  task automatic step(input int w, input logic iv,
                      input logic [31:0] ins, input logic ordy,
                      input logic fl);
    int sz;
    int dp;
    logic ps, pp;
    q32.in_valid = (w == 0) ? iv : 1'b0;
    q32.out_ready = (w == 0) ? ordy : 1'b0;
    q32.flush = (w == 0) ? fl : 1'b0;
    q32.instr = ins;
    q64.in_valid = (w != 0) ? iv : 1'b0;
    q64.out_ready = (w != 0) ? ordy : 1'b0;
    q64.flush = (w != 0) ? fl : 1'b0;
    q64.instr = ins;
    sz = (w != 0) ? mq1.size() : mq0.size();
    dp = (w != 0) ? 3 : 2;
    ps = iv && (sz < dp);
    pp = ordy && (sz > 0);
    @(posedge clk);
    #1;
    if (w == 0) begin
      if (fl) mq0.delete();
      else begin
        if (pp) void'(mq0.pop_front());
        if (ps) mq0.push_back(ins);
      end
    end else begin
      if (fl) mq1.delete();
      else begin
        if (pp) void'(mq1.pop_front());
        if (ps) mq1.push_back(ins);
      end
    end
    chk_state(w);
  endtask

  vec_t vt [12];
  logic [6:0] ops [11];

  initial begin
    vt[0]  = '{32'hFFF00093, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF};
    vt[1]  = '{32'h0020A423, 3'd2, 1'b0, 64'h8};
    vt[2]  = '{32'hFE000EE3, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC};
    vt[3]  = '{32'h00000000, 3'd7, 1'b1, 64'h0};
    vt[4]  = '{32'h800000B7, 3'd4, 1'b0, 64'hFFFFFFFF80000000};
    vt[5]  = '{32'h00B50533, 3'd0, 1'b0, 64'h0};
    vt[6]  = '{32'h008000EF, 3'd5, 1'b0, 64'h8};
    vt[7]  = '{32'h12345037, 3'd4, 1'b0, 64'h12345000};
    vt[8]  = '{32'h0000007F, 3'd7, 1'b1, 64'h0};
    vt[9]  = '{32'h00100073, 3'd1, 1'b0, 64'h1};
    vt[10] = '{32'hFFF00067, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF};
    vt[11] = '{32'hFFFFF017, 3'd4, 1'b0, 64'hFFFFFFFFFFFFF000};
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23,
            7'h63, 7'h37, 7'h17, 7'h6F, 7'h0B};

    q32.in_valid = 0; q32.out_ready = 0; q32.flush = 0;
    q32.instr = 0;
    q64.in_valid = 0; q64.out_ready = 0; q64.flush = 0;
    q64.instr = 0;

    #3;
    chk_state(0);
    chk_state(1);
    @(posedge clk); #1;
    chk_state(0);
    @(negedge clk);
    rst = 1'b0;

    step(0, 1, 32'hFFF00093, 0, 0);
    chk("first_push_cnt", 64'(q32.count), 64'd1);
    chk("first_push_imm", 64'(q32.imm), 64'hFFFFFFFF);
    step(0, 0, 0, 1, 0);

    for (int i = 0; i < 12; i++) begin
      for (int w = 0; w < 2; w++) begin
        step(w, 1, vt[i].instr, 0, 0);
        if (w == 0) begin
          chk($sformatf("vt%0d_fmt32", i), 64'(q32.fmt),
              64'(vt[i].fmt));
          chk($sformatf("vt%0d_ill32", i), 64'(q32.illegal),
              64'(vt[i].illegal));
          chk($sformatf("vt%0d_imm32", i), 64'(q32.imm),
              {32'b0, vt[i].imm[31:0]});
        end else begin
          chk($sformatf("vt%0d_fmt64", i), 64'(q64.fmt),
              64'(vt[i].fmt));
          chk($sformatf("vt%0d_ill64", i), 64'(q64.illegal),
              64'(vt[i].illegal));
          chk($sformatf("vt%0d_imm64", i), q64.imm, vt[i].imm);
        end
        step(w, 0, 0, 1, 0);
      end
    end

    step(0, 1, 32'h0020A423, 1, 0);
    chk("ord_a_fmt", 64'(q32.fmt), 64'd2);
    step(0, 1, 32'hFE000EE3, 1, 0);
    chk("ord_b_fmt", 64'(q32.fmt), 64'd3);
    chk("ord_b_imm", 64'(q32.imm), 64'hFFFFFFFC);
    step(0, 0, 0, 1, 0);

    step(0, 1, 32'h00B50533, 0, 0);
    step(0, 1, 32'h008000EF, 0, 0);
    step(0, 1, 32'h12345037, 0, 0);
    chk("full_cnt", 64'(q32.count), 64'd2);
    chk("full_rdy", 64'(q32.in_ready), 64'd0);
    chk("full_head", 64'(q32.opcode), 64'h33);
    step(0, 0, 0, 1, 0);
    chk("rdy_after_pop", 64'(q32.in_ready), 64'd1);
    chk("second_head", 64'(q32.opcode), 64'h6F);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("empty_pop_cnt", 64'(q32.count), 64'd0);

    step(0, 1, 32'h00100073, 0, 0);
    step(0, 1, 32'hFFF00067, 1, 1);
    chk("flush_cnt", 64'(q32.count), 64'd0);
    chk("flush_valid", 64'(q32.out_valid), 64'd0);

    step(0, 1, 32'h00B50533, 0, 0);
    step(0, 1, 32'h0020A423, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    mq0.delete();
    mq1.delete();
    chk("rst_async_cnt", 64'(q32.count), 64'd0);
    chk("rst_async_valid", 64'(q32.out_valid), 64'd0);
    chk_state(0);
    #1;
    rst = 1'b0;
    step(0, 1, 32'h800000B7, 0, 0);
    chk("post_rst_push", 64'(q32.count), 64'd1);
    step(0, 0, 0, 1, 0);

    for (int n = 0; n < 800; n++) begin
      logic [31:0] ins;
      int w;
      w = n & 1;
      ins = $urandom;
      if ($urandom_range(3) != 0)
        ins[6:0] = ops[$urandom_range(10)];
      step(w, 1'($urandom_range(1)), ins,
           1'($urandom_range(2) != 0),
           1'($urandom_range(31) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
